ifetch_prefetch_stage: RTL and testbench
========================================

# ifetch_prefetch_stage

Parametrised instruction-fetch stage with a prefetch queue and a working PC redirect. It issues sequential word reads on the instruction membus, buffers up to `FETCH_DEPTH` fetched {pc, instruction} pairs, and hands them to decode with a valid/ready handshake. On a writeback redirect it flushes the queue, discards any in-flight response and restarts fetch at the target. It sits between the instruction membus and the decode stage.

## Interface
- `FETCH_DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, `ELF_START`: fetch address after reset.
- `clk` in 1: sole clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `membus_if_io` `rvga_membus_io.master`: `addr_o`, `read_o`, `write_o`, `wdata_o` out; `resp_i`, `rdata_i` in.
- `ifetch_decode_instruction` out 32: head-entry instruction.
- `ifetch_decode_pc` out 32: head-entry PC.
- `ifetch_decode_v` out 1: head entry valid.
- `decode_ifetch_ready` in 1: decode consumes the head when high with `ifetch_decode_v`.
- `writeback_ifetch_pc_target` in 32: redirect address; bits [1:0] are ignored and treated as 0.
- `writeback_ifetch_pc_redirect_v` in 1: redirect strobe, one cycle.

## Operation
- Registers:
  - `fetch_pc`: address of the current or next request.
  - Queue of {pc, instr} entries, with `count` 0..`FETCH_DEPTH`.
  - FSM with states IDLE, REQ, DROP.
- Fixed outputs: `write_o` = 0 and `wdata_o` = 0 always. `addr_o` = `fetch_pc` always.
- `read_o` = 1 in REQ and DROP, 0 in IDLE.
- A request is held, with `addr_o` stable, until `resp_i`. Only one request is outstanding.
- Definitions: `push` = REQ & `resp_i` & !redirect. `pop` = `ifetch_decode_v` & `decode_ifetch_ready` & !redirect. `count_next` = `count` + `push` − `pop`.
- IDLE:
  - redirect → REQ.
  - else if `count` < `FETCH_DEPTH` → REQ.
  - else stay in IDLE.
- REQ:
  - redirect & !`resp_i` → DROP.
  - redirect & `resp_i` → REQ; the response is discarded.
  - `resp_i` → push {`fetch_pc`, `rdata_i`}, `fetch_pc` += 4; go to REQ if `count_next` < `FETCH_DEPTH`, else IDLE.
  - otherwise hold.
- DROP:
  - `resp_i` → REQ; `rdata_i` is discarded.
  - redirect → stay in DROP; the latest target wins.
- Redirect, in any state:
  - `fetch_pc` ← {target[31:2], 2'b00}.
  - `count` ← 0 and queue pointers cleared.
  - A same-cycle pop is cancelled.
- `fetch_pc` wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Queue is empty: `ifetch_decode_v` = 0. The instruction and PC outputs are don't-care, but driven from the head-entry storage, never X-propagating logic.
- Queue is full and popped in the same cycle as a push: legal; `count` is unchanged.
- Reset mid-transaction:
  - state IDLE, `count` 0, `fetch_pc` = `RESET_PC`.
  - A late `resp_i` arriving in IDLE is ignored. The membus must not respond without `read_o`.

## Timing
- Reset values:
  - `read_o` = 0, `addr_o` = `RESET_PC`, `ifetch_decode_v` = 0.
  - `ifetch_decode_instruction` = 0, `ifetch_decode_pc` = 0.
  - State IDLE.
- First `read_o` is asserted in the first cycle after `rst` deasserts.
- Response to decode latency: `resp_i` in cycle N → entry visible, `ifetch_decode_v` = 1, in cycle N+1.
- Redirect to first request latency: redirect in cycle N → `read_o` = 1 with `addr_o` = target in N+1, unless in DROP.
- Throughput: one word per cycle when the membus responds in the same cycle as `read_o` and decode is always ready.
- IDLE→REQ costs one bubble cycle after the queue leaves full.
- All outputs are registered or decoded directly from state registers. There is no combinational path from `resp_i` or `decode_ifetch_ready` to `read_o` or `addr_o`.

## Structure
- Add to `rvga_types`:
  - `ifetch_entry_s` = {`rvga_word pc`, `rvga_word instr`}.
  - `ifetch_state_e` = {IDLE, REQ, DROP}.
- `ELF_START` stays in `rvga_defines`.
- One sub-module: `rvga_sync_fifo`, parametrised by type/width and depth.
  - Ports: push, pop, flush, full, empty, count.
  - Registered storage, pointer wrap on power-of-two depth.
- The FSM and `fetch_pc` live in `ifetch_prefetch_stage`.

## Test plan
- Reset, then a 0-wait memory and decode always ready: PCs `ELF_START`, +4, +8, … appear on consecutive cycles with matching `rdata_i`. `ifetch_decode_v` first rises 2 cycles after reset deasserts.
- Decode stalled (ready = 0), `FETCH_DEPTH` = 4: exactly 4 responses accepted, then `read_o` = 0. Raise ready: entries pop in order and fetch resumes at PC + 16.
- Redirect to 0x0000_0103 while a 3-cycle memory request is outstanding: the late response is discarded, the queue is empty, and the next `addr_o` is 0x0000_0100.
- Redirect in the same cycle as `resp_i` and decode pop: no push, no pop, `count` = 0, next `addr_o` = target.
- Queue full with simultaneous pop and push: `count` stays 4 and order is preserved.
- `fetch_pc` = 0xFFFF_FFFC: the next request goes to 0x0000_0000.
- Assert `rst` mid-request: outputs return to their reset values, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_prefetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: word type, queue entry, FSM states.
package ifetch_prefetch_stage_pkg;

    typedef logic [31:0] rvga_word;

    localparam rvga_word ELF_START = 32'h0000_1000;

    typedef struct packed {
        rvga_word pc;
        rvga_word instr;
    } ifetch_entry_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_prefetch_stage_if.sv
// Instruction membus: single-outstanding word read, held until resp_i.
interface rvga_membus_io;
    import ifetch_prefetch_stage_pkg::*;

    rvga_word addr_o;
    logic     read_o;
    logic     write_o;
    rvga_word wdata_o;
    logic     resp_i;
    rvga_word rdata_i;

    modport master (
        output addr_o, read_o, write_o, wdata_o,
        input  resp_i, rdata_i
    );

    modport slave (
        input  addr_o, read_o, write_o, wdata_o,
        output resp_i, rdata_i
    );

endinterface

// File: rtl/ifetch_prefetch_stage_fifo.sv
// Synchronous FIFO with registered storage; depth must be a power of two so pointers wrap naturally.
module rvga_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_prefetch_stage.sv
// Instruction fetch with prefetch queue and writeback redirect.
// state | meaning
// IDLE  | queue full, no request on the bus
// REQ   | read outstanding at fetch_pc; response is pushed
// DROP  | read outstanding from before a redirect; response is discarded
module ifetch_prefetch_stage
    import ifetch_prefetch_stage_pkg::*;
#(
    parameter int       FETCH_DEPTH = 4,
    parameter rvga_word RESET_PC    = ELF_START
) (
    input  logic                 clk,
    input  logic                 rst,
    rvga_membus_io.master        membus_if_io,
    output rvga_word             ifetch_decode_instruction,
    output rvga_word             ifetch_decode_pc,
    output logic                 ifetch_decode_v,
    input  logic                 decode_ifetch_ready,
    input  rvga_word             writeback_ifetch_pc_target,
    input  logic                 writeback_ifetch_pc_redirect_v
);

    localparam int CW = $clog2(FETCH_DEPTH) + 1;

    ifetch_state_e state_q, state_d;
    rvga_word      fetch_pc_q, fetch_pc_d;
    logic          redirect, push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] count;
    logic [CW:0]   count_next;
    ifetch_entry_s wr_entry, head;

    assign redirect = writeback_ifetch_pc_redirect_v;
    assign push     = (state_q == REQ) & membus_if_io.resp_i & ~redirect;
    assign pop      = ~fifo_empty & decode_ifetch_ready & ~redirect;
    assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

    assign wr_entry = '{pc: fetch_pc_q, instr: membus_if_io.rdata_i};

    rvga_sync_fifo #(
        .WIDTH ($bits(ifetch_entry_s)),
        .DEPTH (FETCH_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect || (count < CW'(FETCH_DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = membus_if_io.resp_i ? REQ : DROP;
                end else if (membus_if_io.resp_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_next < (CW+1)'(FETCH_DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (membus_if_io.resp_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = {writeback_ifetch_pc_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign membus_if_io.addr_o  = fetch_pc_q;
    assign membus_if_io.read_o  = (state_q != IDLE);
    assign membus_if_io.write_o = 1'b0;
    assign membus_if_io.wdata_o = '0;

    assign ifetch_decode_v           = ~fifo_empty;
    assign ifetch_decode_pc          = head.pc;
    assign ifetch_decode_instruction = head.instr;

endmodule

// File: tb/tb_ifetch_prefetch_stage.sv
// Directed per-cycle vector table plus hand sequences for wrap and late-response redirect.
module tb_ifetch_prefetch_stage;
    import ifetch_prefetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        resp;
    logic        rdv;
    logic [31:0] tgt;
    rvga_word    dec_instr, dec_pc;
    logic        dec_v;

    int n_vec = 0;
    int n_err = 0;

    rvga_membus_io bus ();

    // Memory returns the bit-inverse of the address as the instruction word.
    assign bus.resp_i  = resp;
    assign bus.rdata_i = ~bus.addr_o;

    ifetch_prefetch_stage #(
        .FETCH_DEPTH (4),
        .RESET_PC    (32'h0000_1000)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .membus_if_io                   (bus.master),
        .ifetch_decode_instruction      (dec_instr),
        .ifetch_decode_pc               (dec_pc),
        .ifetch_decode_v                (dec_v),
        .decode_ifetch_ready            (ready),
        .writeback_ifetch_pc_target     (tgt),
        .writeback_ifetch_pc_redirect_v (rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        resp;
        logic        rdv;
        logic [31:0] tgt;
        logic        exp_rd;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt [28];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic rs, input logic rv,
                         input logic [31:0] t);
        @(negedge clk);
        rst   = r;
        ready = rd;
        resp  = rs;
        rdv   = rv;
        tgt   = t;
    endtask

    initial begin
        // rst rdy resp rdv tgt | rd addr v chk_pc pc
        vt[0]  = '{1,1,0,0,32'h0,   0,32'h0000_1000,0,1,32'h0};
        vt[1]  = '{0,1,1,0,32'h0,   0,32'h0000_1000,0,1,32'h0};
        vt[2]  = '{0,1,1,0,32'h0,   1,32'h0000_1000,0,0,32'h0};
        vt[3]  = '{0,1,1,0,32'h0,   1,32'h0000_1004,1,0,32'h0000_1000};
        vt[4]  = '{0,1,1,0,32'h0,   1,32'h0000_1008,1,0,32'h0000_1004};
        vt[5]  = '{0,1,1,1,32'h103, 1,32'h0000_100C,1,0,32'h0000_1008};
        vt[6]  = '{0,1,0,0,32'h0,   1,32'h0000_0100,0,0,32'h0};
        vt[7]  = '{0,1,1,0,32'h0,   1,32'h0000_0100,0,0,32'h0};
        vt[8]  = '{0,1,0,0,32'h0,   1,32'h0000_0104,1,0,32'h0000_0100};
        vt[9]  = '{0,1,0,1,32'h200, 1,32'h0000_0104,0,0,32'h0};
        vt[10] = '{0,1,0,1,32'h304, 1,32'h0000_0200,0,0,32'h0};
        vt[11] = '{0,1,1,0,32'h0,   1,32'h0000_0304,0,0,32'h0};
        vt[12] = '{0,0,1,0,32'h0,   1,32'h0000_0304,0,0,32'h0};
        vt[13] = '{0,0,1,0,32'h0,   1,32'h0000_0308,1,0,32'h0000_0304};
        vt[14] = '{0,0,1,0,32'h0,   1,32'h0000_030C,1,0,32'h0000_0304};
        vt[15] = '{0,0,1,0,32'h0,   1,32'h0000_0310,1,0,32'h0000_0304};
        vt[16] = '{0,0,1,0,32'h0,   0,32'h0000_0314,1,0,32'h0000_0304};
        vt[17] = '{0,1,0,0,32'h0,   0,32'h0000_0314,1,0,32'h0000_0304};
        vt[18] = '{0,1,0,0,32'h0,   0,32'h0000_0314,1,0,32'h0000_0308};
        vt[19] = '{0,0,1,0,32'h0,   1,32'h0000_0314,1,0,32'h0000_030C};
        vt[20] = '{0,1,1,0,32'h0,   1,32'h0000_0318,1,0,32'h0000_030C};
        vt[21] = '{0,1,1,0,32'h0,   1,32'h0000_031C,1,0,32'h0000_0310};
        vt[22] = '{0,1,0,0,32'h0,   1,32'h0000_0320,1,0,32'h0000_0314};
        vt[23] = '{0,1,0,0,32'h0,   1,32'h0000_0320,1,0,32'h0000_0318};
        vt[24] = '{0,1,0,0,32'h0,   1,32'h0000_0320,1,0,32'h0000_031C};
        vt[25] = '{1,1,0,0,32'h0,   1,32'h0000_0320,0,0,32'h0};
        vt[26] = '{0,1,0,0,32'h0,   0,32'h0000_1000,0,1,32'h0};
        vt[27] = '{0,1,0,0,32'h0,   1,32'h0000_1000,0,0,32'h0};

        rst = 1'b1; ready = 1'b0; resp = 1'b0; rdv = 1'b0; tgt = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 28; i++) begin
            drive(vt[i].rst, vt[i].rdy, vt[i].resp, vt[i].rdv, vt[i].tgt);
            chk($sformatf("v%0d read_o", i), {31'b0, bus.read_o}, {31'b0, vt[i].exp_rd});
            chk($sformatf("v%0d addr_o", i), bus.addr_o, vt[i].exp_addr);
            chk($sformatf("v%0d valid", i), {31'b0, dec_v}, {31'b0, vt[i].exp_v});
            if (vt[i].exp_v) begin
                chk($sformatf("v%0d pc", i), dec_pc, vt[i].exp_pc);
                chk($sformatf("v%0d instr", i), dec_instr, ~vt[i].exp_pc);
            end else if (vt[i].chk_pc) begin
                chk($sformatf("v%0d reset pc", i), dec_pc, 32'h0);
                chk($sformatf("v%0d reset instr", i), dec_instr, 32'h0);
            end
            if (i == 0 || i == 20) begin
                chk($sformatf("v%0d write_o", i), {31'b0, bus.write_o}, 32'h0);
                chk($sformatf("v%0d wdata_o", i), bus.wdata_o, 32'h0);
            end
        end

        // fetch_pc wrap: redirect to the top word, then the following request lands at 0.
        drive(0, 1, 0, 1, 32'hFFFF_FFFF);
        drive(0, 1, 1, 0, 32'h0);
        chk("wrap drop addr", bus.addr_o, 32'hFFFF_FFFC);
        drive(0, 1, 1, 0, 32'h0);
        chk("wrap req addr", bus.addr_o, 32'hFFFF_FFFC);
        chk("wrap req valid", {31'b0, dec_v}, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        chk("wrap next addr", bus.addr_o, 32'h0000_0000);
        chk("wrap valid", {31'b0, dec_v}, 32'h1);
        chk("wrap pc", dec_pc, 32'hFFFF_FFFC);
        chk("wrap instr", dec_instr, 32'h0000_0003);

        // 3-cycle memory at 0x400, redirected to 0x103 before the response returns.
        drive(0, 1, 0, 1, 32'h400);
        drive(0, 1, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        chk("lat req addr", bus.addr_o, 32'h0000_0400);
        chk("lat req read", {31'b0, bus.read_o}, 32'h1);
        drive(0, 1, 0, 1, 32'h103);
        drive(0, 1, 1, 0, 32'h0);
        chk("lat drop addr", bus.addr_o, 32'h0000_0100);
        drive(0, 1, 0, 0, 32'h0);
        chk("lat discarded valid", {31'b0, dec_v}, 32'h0);
        chk("lat restart addr", bus.addr_o, 32'h0000_0100);
        chk("lat restart read", {31'b0, bus.read_o}, 32'h1);
        drive(0, 1, 1, 0, 32'h0);
        begin
            int k = 0;
            drive(0, 1, 0, 0, 32'h0);
            while (!dec_v && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("lat wait valid", {31'b0, dec_v}, 32'h1);
            chk("lat pc", dec_pc, 32'h0000_0100);
            chk("lat instr", dec_instr, 32'hFFFF_FEFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
